// File: rtl/robot_pkg.sv
// Shared definitions for the wall-following cleaning robot controller.
package robot_pkg;

    localparam int DEF_ROWS = 10;
    localparam int DEF_COLS = 20;

    typedef enum logic [1:0] {
        OR_NORTH = 2'b00,
        OR_SOUTH = 2'b01,
        OR_EAST  = 2'b10,
        OR_WEST  = 2'b11
    } orient_t;

    typedef enum logic [1:0] {
        ST_SEARCH      = 2'b00,
        ST_FOLLOW      = 2'b01,
        ST_TURNED_LEFT = 2'b10,
        ST_CLEAN       = 2'b11
    } ctrl_state_t;

    // Clockwise rotation: N -> E -> S -> W -> N
    function automatic orient_t turn_right(input orient_t o);
        case (o)
            OR_NORTH: return OR_EAST;
            OR_EAST:  return OR_SOUTH;
            OR_SOUTH: return OR_WEST;
            default:  return OR_NORTH;
        endcase
    endfunction

    // Counter-clockwise rotation: N -> W -> S -> E -> N
    function automatic orient_t turn_left(input orient_t o);
        case (o)
            OR_NORTH: return OR_WEST;
            OR_WEST:  return OR_SOUTH;
            OR_SOUTH: return OR_EAST;
            default:  return OR_NORTH;
        endcase
    endfunction

endpackage

// File: rtl/robot_pos_step.sv
// Combinational position stepper: the cell straight ahead plus flags saying
// whether the cell ahead / to the left lies outside the map.
module robot_pos_step
    import robot_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic [5:0] row,
    input  logic [5:0] col,
    input  logic [1:0] orient,
    output logic [5:0] fwd_row,
    output logic [5:0] fwd_col,
    output logic       edge_ahead,
    output logic       edge_left
);

    localparam logic [5:0] LAST_ROW = 6'(ROWS);
    localparam logic [5:0] LAST_COL = 6'(COLS);

    // Forward cell is only used when edge_ahead is clear, so wrap at an edge is harmless
    always_comb begin
        fwd_row    = row;
        fwd_col    = col;
        edge_ahead = 1'b0;
        edge_left  = 1'b0;
        case (orient_t'(orient))
            OR_NORTH: begin
                fwd_row    = row - 6'd1;
                edge_ahead = (row <= 6'd1);
                edge_left  = (col <= 6'd1);
            end
            OR_SOUTH: begin
                fwd_row    = row + 6'd1;
                edge_ahead = (row >= LAST_ROW);
                edge_left  = (col >= LAST_COL);
            end
            OR_EAST: begin
                fwd_col    = col + 6'd1;
                edge_ahead = (col >= LAST_COL);
                edge_left  = (row <= 6'd1);
            end
            default: begin
                fwd_col    = col - 6'd1;
                edge_ahead = (col <= 6'd1);
                edge_left  = (row >= LAST_ROW);
            end
        endcase
    end

endmodule

// File: rtl/robot_controller.sv
// Left-hand wall-following robot with cleaning stops, move counter and
// stuck detection. One action per tick; map edges behave as obstacles.
module robot_controller
    import robot_pkg::*;
#(
    parameter int         ROWS         = DEF_ROWS,
    parameter int         COLS         = DEF_COLS,
    parameter int         START_ROW    = 10,
    parameter int         START_COL    = 1,
    parameter logic [1:0] START_ORIENT = 2'b00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        head,
    input  logic        left,
    input  logic        under,
    input  logic        clean_ack,
    output logic [5:0]  robot_row,
    output logic [5:0]  robot_column,
    output logic [1:0]  robot_orientation,
    output logic        clean_req,
    output logic [15:0] move_count,
    output logic        stuck
);

    logic [5:0]  row_q, row_d, col_q, col_d;
    orient_t     orient_q, orient_d;
    ctrl_state_t state_q, state_d, saved_q, saved_d;
    logic        clean_req_q, clean_req_d;
    logic [15:0] move_count_q, move_count_d;
    logic [2:0]  turn_cnt_q, turn_cnt_d;
    logic        stuck_q, stuck_d;

    logic [5:0]  fwd_row, fwd_col;
    logic        edge_ahead, edge_left;
    logic        eff_head, eff_left;
    logic        do_fwd, do_right, do_left;

    robot_pos_step #(.ROWS(ROWS), .COLS(COLS)) u_step (
        .row        (row_q),
        .col        (col_q),
        .orient     (orient_q),
        .fwd_row    (fwd_row),
        .fwd_col    (fwd_col),
        .edge_ahead (edge_ahead),
        .edge_left  (edge_left)
    );

    // State register: everything returns to the start pose on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_q        <= 6'(START_ROW);
            col_q        <= 6'(START_COL);
            orient_q     <= orient_t'(START_ORIENT);
            state_q      <= ST_SEARCH;
            saved_q      <= ST_SEARCH;
            clean_req_q  <= 1'b0;
            move_count_q <= '0;
            turn_cnt_q   <= '0;
            stuck_q      <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            orient_q     <= orient_d;
            state_q      <= state_d;
            saved_q      <= saved_d;
            clean_req_q  <= clean_req_d;
            move_count_q <= move_count_d;
            turn_cnt_q   <= turn_cnt_d;
            stuck_q      <= stuck_d;
        end
    end

    // Next state: dirt check first, then the wall-following rules pick one action
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        orient_d     = orient_q;
        state_d      = state_q;
        saved_d      = saved_q;
        clean_req_d  = clean_req_q;
        move_count_d = move_count_q;
        turn_cnt_d   = turn_cnt_q;
        stuck_d      = stuck_q;
        do_fwd       = 1'b0;
        do_right     = 1'b0;
        do_left      = 1'b0;
        eff_head     = head | edge_ahead;
        eff_left     = left | edge_left;

        if (state_q == ST_CLEAN) begin
            // Ticks are ignored while cleaning; only the ack releases us
            if (clean_ack) begin
                clean_req_d = 1'b0;
                state_d     = saved_q;
            end
        end else if (tick) begin
            if (under) begin
                saved_d     = state_q;
                state_d     = ST_CLEAN;
                clean_req_d = 1'b1;
            end else begin
                case (state_q)
                    ST_SEARCH: begin
                        if (eff_head) begin
                            do_right = 1'b1;
                            state_d  = ST_FOLLOW;
                        end else begin
                            do_fwd = 1'b1;
                        end
                    end
                    ST_FOLLOW: begin
                        if (!eff_left) begin
                            do_left = 1'b1;
                            state_d = ST_TURNED_LEFT;
                        end else if (!eff_head) begin
                            do_fwd = 1'b1;
                        end else begin
                            do_right = 1'b1;
                        end
                    end
                    ST_TURNED_LEFT: begin
                        state_d  = ST_FOLLOW;
                        do_fwd   = !eff_head;
                        do_right = eff_head;
                    end
                    default: ;
                endcase
            end
        end

        if (do_fwd) begin
            row_d      = fwd_row;
            col_d      = fwd_col;
            turn_cnt_d = '0;
            if (move_count_q != 16'hFFFF)
                move_count_d = move_count_q + 16'd1;
        end
        if (do_right) begin
            orient_d = turn_right(orient_q);
            // Counter holds at 4 once a full spin in place has been seen
            if (turn_cnt_q >= 3'd3) begin
                turn_cnt_d = 3'd4;
                stuck_d    = 1'b1;
            end else begin
                turn_cnt_d = turn_cnt_q + 3'd1;
            end
        end
        if (do_left) begin
            orient_d   = turn_left(orient_q);
            turn_cnt_d = '0;
        end
    end

    // Outputs come straight from the registers
    always_comb begin
        robot_row         = row_q;
        robot_column      = col_q;
        robot_orientation = orient_q;
        clean_req         = clean_req_q;
        move_count        = move_count_q;
        stuck             = stuck_q;
    end

endmodule

// File: tb/tb_robot_controller.sv
// Self-checking bench for robot_controller: directed vector table, directed
// corner-case sequences, then randomized traffic against a grid-walk model.
module tb_robot_controller;
    import robot_pkg::*;

    localparam int ROWS = 10;
    localparam int COLS = 20;

    logic        clock, reset, tick, head, left, under, clean_ack;
    logic [5:0]  robot_row, robot_column;
    logic [1:0]  robot_orientation;
    logic        clean_req, stuck;
    logic [15:0] move_count;

    int n_chk  = 0;
    int n_fail = 0;

    robot_controller dut (
        .clock             (clock),
        .reset             (reset),
        .tick              (tick),
        .head              (head),
        .left              (left),
        .under             (under),
        .clean_ack         (clean_ack),
        .robot_row         (robot_row),
        .robot_column      (robot_column),
        .robot_orientation (robot_orientation),
        .clean_req         (clean_req),
        .move_count        (move_count),
        .stuck             (stuck)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model (compass walk on a grid) ----------------
    // Heading index 0..3 = N,E,S,W (clockwise); mode 0..3 = search/follow/turned/clean
    int          dr[4]   = '{-1, 0, 1, 0};
    int          dc[4]   = '{0, 1, 0, -1};
    logic [1:0]  code[4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    int m_r, m_c, m_h, m_mode, m_saved, m_mc, m_turns;
    bit m_req, m_stuck;

    function automatic bit off_map(input int r, input int c);
        return (r < 1) || (r > ROWS) || (c < 1) || (c > COLS);
    endfunction

    task automatic model_reset();
        m_r = 10; m_c = 1; m_h = 0; m_mode = 0; m_saved = 0;
        m_mc = 0; m_turns = 0; m_req = 0; m_stuck = 0;
    endtask

    task automatic m_fwd();
        m_r += dr[m_h]; m_c += dc[m_h];
        if (m_mc < 65535) m_mc++;
        m_turns = 0;
    endtask

    task automatic m_right();
        m_h = (m_h + 1) % 4;
        m_turns++;
        if (m_turns >= 4) m_stuck = 1;
    endtask

    task automatic m_left();
        m_h = (m_h + 3) % 4;
        m_turns = 0;
    endtask

    task automatic model_step(input bit t, input bit h, input bit l, input bit u, input bit a);
        bit eh, el;
        int lh;
        lh = (m_h + 3) % 4;
        eh = h || off_map(m_r + dr[m_h], m_c + dc[m_h]);
        el = l || off_map(m_r + dr[lh], m_c + dc[lh]);
        if (m_mode == 3) begin
            if (a) begin m_req = 0; m_mode = m_saved; end
        end else if (t) begin
            if (u) begin
                m_saved = m_mode; m_mode = 3; m_req = 1;
            end else if (m_mode == 0) begin
                if (eh) begin m_right(); m_mode = 1; end
                else m_fwd();
            end else if (m_mode == 1) begin
                if (!el) begin m_left(); m_mode = 2; end
                else if (!eh) m_fwd();
                else m_right();
            end else begin
                if (!eh) m_fwd(); else m_right();
                m_mode = 1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_pose(input string name, input int r, input int c, input logic [1:0] o);
        chk({name, ".row"}, 32'(robot_row), r);
        chk({name, ".col"}, 32'(robot_column), c);
        chk({name, ".orient"}, 32'(robot_orientation), 32'(o));
    endtask

    task automatic step(input logic t, input logic h, input logic l, input logic u, input logic a);
        tick = t; head = h; left = l; under = u; clean_ack = a;
        @(posedge clock);
        #1;
    endtask

    // Reset is pulsed between clock edges (we sit at posedge+1 here)
    task automatic do_reset();
        tick = 0; head = 0; left = 0; under = 0; clean_ack = 0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    typedef struct {
        logic       t, h, l, u;
        int         row, col;
        logic [1:0] ori;
        int         mc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        reset = 1'b1; tick = 0; head = 0; left = 0; under = 0; clean_ack = 0;
        #3;
        // Reset state
        chk_pose("rst", 10, 1, OR_NORTH);
        chk("rst.clean_req", 32'(clean_req), 0);
        chk("rst.move_count", 32'(move_count), 0);
        chk("rst.stuck", 32'(stuck), 0);
        @(negedge clock);
        reset = 1'b0;

        // ---- vector table, applied from the start pose ----
        vecs[0]  = '{1, 0, 0, 0, 9, 1, OR_NORTH, 1};
        vecs[1]  = '{1, 0, 0, 0, 8, 1, OR_NORTH, 2};
        vecs[2]  = '{1, 0, 0, 0, 7, 1, OR_NORTH, 3};
        vecs[3]  = '{0, 1, 0, 0, 7, 1, OR_NORTH, 3};
        vecs[4]  = '{1, 1, 0, 0, 7, 1, OR_EAST,  3};
        vecs[5]  = '{1, 0, 1, 0, 7, 2, OR_EAST,  4};
        vecs[6]  = '{1, 1, 1, 0, 7, 2, OR_SOUTH, 4};
        vecs[7]  = '{1, 0, 0, 0, 7, 2, OR_EAST,  4};
        vecs[8]  = '{1, 1, 0, 0, 7, 2, OR_SOUTH, 4};
        vecs[9]  = '{1, 0, 1, 0, 8, 2, OR_SOUTH, 5};
        vecs[10] = '{1, 0, 0, 0, 8, 2, OR_EAST,  5};
        vecs[11] = '{1, 0, 0, 0, 8, 3, OR_EAST,  6};
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].t, vecs[i].h, vecs[i].l, vecs[i].u, 1'b0);
            chk_pose($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].ori);
            chk($sformatf("vec%0d.mc", i), 32'(move_count), vecs[i].mc);
            if (i == 2)
                chk("vec2.state", 32'(dut.state_q), 32'(ST_SEARCH));
        end

        // ---- top edge counts as obstacle ----
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        chk_pose("edge.pre", 1, 1, OR_NORTH);
        step(1, 0, 0, 0, 0);
        chk_pose("edge.turn", 1, 1, OR_EAST);
        chk("edge.state", 32'(dut.state_q), 32'(ST_FOLLOW));
        chk("edge.mc", 32'(move_count), 9);

        // ---- FOLLOW at (5,5,east), open left: turn left then forward ----
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
        chk_pose("fl.pre", 5, 5, OR_EAST);
        step(1, 0, 0, 0, 0);
        chk_pose("fl.t1", 5, 5, OR_NORTH);
        chk("fl.t1.state", 32'(dut.state_q), 32'(ST_TURNED_LEFT));
        step(1, 0, 0, 0, 0);
        chk_pose("fl.t2", 4, 5, OR_NORTH);
        chk("fl.t2.state", 32'(dut.state_q), 32'(ST_FOLLOW));

        // ---- cleaning stop freezes motion, ack resumes prior state ----
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk_pose("cl.pre", 9, 1, OR_EAST);
        step(0, 0, 0, 0, 1);                 // ack outside CLEAN ignored
        chk("cl.stray_ack", 32'(dut.state_q), 32'(ST_FOLLOW));
        step(1, 0, 1, 1, 0);
        chk("cl.req", 32'(clean_req), 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 0);
            chk_pose($sformatf("cl.frz%0d", i), 9, 1, OR_EAST);
            chk($sformatf("cl.frz%0d.req", i), 32'(clean_req), 1);
        end
        step(0, 0, 0, 0, 1);
        chk("cl.ack.req", 32'(clean_req), 0);
        chk("cl.ack.state", 32'(dut.state_q), 32'(ST_FOLLOW));
        step(1, 0, 1, 0, 0);
        chk_pose("cl.resume", 9, 2, OR_EAST);

        // ---- four right turns in FOLLOW -> full spin, stuck ----
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 0, 0);
            chk(
                $sformatf("spin%0d.stuck", i), 32'(stuck), (i == 3) ? 1 : 0);
        end
        chk_pose("spin.end", 9, 2, OR_EAST);
        step(1, 0, 1, 0, 0);
        chk_pose("spin.keep_acting", 9, 3, OR_EAST);
        chk("spin.sticky", 32'(stuck), 1);

        // ---- reset in the middle of CLEAN ----
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("rc.req", 32'(clean_req), 1);
        #1 reset = 1'b1;
        #1;
        chk("rc.req_async", 32'(clean_req), 0);
        chk_pose("rc.pose", 10, 1, OR_NORTH);
        chk("rc.mc", 32'(move_count), 0);
        @(negedge clock);
        reset = 1'b0;
        step(1, 0, 0, 0, 0);
        chk_pose("rc.first_tick", 9, 1, OR_NORTH);

        // ---- randomized run against the model ----
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic t, h, l, u, a;
            t = ($urandom % 4) != 0;
            h = ($urandom % 4) == 0;
            l = ($urandom % 2) == 1;
            u = ($urandom % 16) == 0;
            a = ($urandom % 4) == 0;
            step(t, h, l, u, a);
            model_step(t, h, l, u, a);
            chk_pose($sformatf("rnd%0d", i), m_r, m_c, code[m_h]);
            chk($sformatf("rnd%0d.req", i), 32'(clean_req), 32'(m_req));
            chk($sformatf("rnd%0d.mc", i), 32'(move_count), m_mc);
            chk($sformatf("rnd%0d.stuck", i), 32'(stuck), 32'(m_stuck));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/robot_controller.md
ROBOT_CONTROLLER -- requirements
Module: robot_controller

Interface
REQ-001 SHALL have parameter ROWS, default 10, map height in cells (rows 1..ROWS, row 1 = top).
REQ-002 SHALL have parameter COLS, default 20, map width in cells (columns 1..COLS, column 1 = left).
REQ-003 SHALL have parameter START_ROW, default 10, row loaded on reset.
REQ-004 SHALL have parameter START_COL, default 1, column loaded on reset.
REQ-005 SHALL have parameter START_ORIENT, default north (2'b00), orientation loaded on reset.
REQ-006 SHALL have port clock  input  1  single system clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port tick  input  1  one-cycle move-enable pulse; one action per tick.
REQ-009 SHALL have port head  input  1  obstacle in the cell ahead.
REQ-010 SHALL have port left  input  1  obstacle in the cell to the robot's left.
REQ-011 SHALL have port under  input  1  dirt under the robot.
REQ-012 SHALL have port clean_ack  input  1  cleaning finished.
REQ-013 SHALL have port robot_row  output  6  current row.
REQ-014 SHALL have port robot_column  output  6  current column.
REQ-015 SHALL have port robot_orientation  output  2  north=00, south=01, east=10, west=11.
REQ-016 SHALL have port clean_req  output  1  request to clean current cell.
REQ-017 SHALL have port move_count  output  16  forward moves taken, saturating.
REQ-018 SHALL have port stuck  output  1  sticky no-progress flag.

Function
REQ-019 SHALL treat effective head = head OR (forward move would leave 1..ROWS/1..COLS); effective left likewise for the left-hand cell.
REQ-020 SHALL act only on cycles with tick=1; all outputs register on that edge, visible the next cycle (latency 1).
REQ-021 SHALL implement states SEARCH, FOLLOW, TURNED_LEFT, CLEAN.
REQ-022 SEARCH on tick: head -> turn right, go FOLLOW; else move forward, stay.
REQ-023 FOLLOW on tick: !left -> turn left, go TURNED_LEFT; left & !head -> forward; left & head -> turn right, stay.
REQ-024 TURNED_LEFT on tick: !head -> forward, go FOLLOW; head -> turn right, go FOLLOW.
REQ-025 SHALL check under before any move rule: tick with under=1 in non-CLEAN state -> no motion, save current state, go CLEAN, clean_req=1.
REQ-026 CLEAN: tick ignored; clean_ack=1 -> clean_req=0, return to saved state same edge; clean_ack outside CLEAN ignored.
REQ-027 Forward: north row-1, south row+1, east col+1, west col-1; turn right N->E->S->W->N; turn left inverse.
REQ-028 move_count SHALL increment per forward move, saturating at 16'hFFFF.
REQ-029 SHALL count consecutive right turns; reset to 0 on forward move or left turn; reaching 4 sets stuck=1 until reset; robot keeps acting.
REQ-030 Position SHALL never leave the map, even with head=0 at an edge.

Reset
REQ-031 reset=1 SHALL asynchronously force: row=START_ROW, column=START_COL, orientation=START_ORIENT, state=SEARCH, clean_req=0, move_count=0, stuck=0, turn counter=0.
REQ-032 Reset mid-CLEAN SHALL drop clean_req immediately; first tick after release is evaluated from SEARCH.

Structure
REQ-033 Shared package robot_pkg SHALL hold orientation codes, controller state encoding, default ROWS/COLS.
REQ-034 Combinational sub-module robot_pos_step SHALL compute next row/column and edge-ahead/edge-left flags from position, orientation, ROWS, COLS.

Verification
REQ-035 Reset, head=left=under=0, 3 ticks -> (7,1,north), move_count=3, state SEARCH.
REQ-036 At (1,1,north) in SEARCH, head=0, tick -> turn right to east, row stays 1 (edge counts as obstacle), state FOLLOW.
REQ-037 FOLLOW at (5,5,east), left=0, 2 ticks with head=0 -> (4,5,north) after second tick, via TURNED_LEFT.
REQ-038 under=1 with tick -> clean_req=1 next cycle, position frozen across 3 further ticks; clean_ack pulse -> clean_req=0, prior state resumed.
REQ-039 FOLLOW with head=left=1 for 4 ticks -> orientation cycles once fully, stuck=1, position unchanged.
REQ-040 Reset asserted during CLEAN -> clean_req=0 without clock edge; outputs at START values.
